// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, the "no register" ID and
// per-icode format helpers used by the fetch stage.
package y86_pkg;

    localparam int unsigned INSTR_MAX_BYTES = 10;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    // Encoded length in bytes; unknown icodes count as one byte.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
            I_JXX, I_CALL:                    instr_len = 4'd9;
            default:                          instr_len = 4'd1;
        endcase
    endfunction

    // Instruction carries a register-specifier byte at offset 1.
    function automatic logic need_regids(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ:           need_regids = 1'b1;
            default:                          need_regids = 1'b0;
        endcase
    endfunction

    // Instruction carries an 8-byte constant.
    function automatic logic need_valC(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL:                    need_valC = 1'b1;
            default:                          need_valC = 1'b0;
        endcase
    endfunction

    // Legal icode/ifun combination.
    function automatic logic ifun_legal(input logic [3:0] icode, input logic [3:0] ifun);
        case (icode)
            I_RRMOVQ, I_JXX:                  ifun_legal = (ifun <= 4'd6);
            I_OPQ:                            ifun_legal = (ifun <= 4'd3);
            4'hC, 4'hD, 4'hE, 4'hF:           ifun_legal = 1'b0;
            default:                          ifun_legal = (ifun == 4'd0);
        endcase
    endfunction

endpackage

// File: rtl/imem.sv
// Byte-addressed instruction memory: one synchronous write port and ten
// combinational read ports at pc+0..pc+9, each with an out-of-range flag.
module imem #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              we,
    input  logic [63:0]       waddr,
    input  logic [7:0]        wdata,
    input  logic [63:0]       pc,
    output logic [9:0][7:0]   rdata_c,
    output logic [9:0]        oor_c
);

    localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic [7:0] mem [MEM_BYTES];

    // Write port; out-of-range addresses are dropped. Reads see the old byte.
    always_ff @(posedge clk) begin
        if (we && (waddr < 64'(MEM_BYTES))) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    // Read ports; data from an out-of-range port is meaningless and gated upstream.
    for (genvar g = 0; g < 10; g++) begin : g_rd
        logic [63:0] addr;
        assign addr       = pc + 64'(g);
        assign oor_c[g]   = (addr >= 64'(MEM_BYTES));
        assign rdata_c[g] = mem[addr[AW-1:0]];
    end

endmodule

// File: rtl/fetch.sv
// Y86-64 sequential fetch stage: reads the instruction at PC, splits its
// fields, computes the fall-through address and registers everything.
module fetch
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] PC,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error
);

    logic [9:0][7:0] rd_c;
    logic [9:0]      oor_c;

    logic [3:0]  ic_c;
    logic [3:0]  fn_c;
    logic [3:0]  len_c;
    logic        err_c;
    logic [3:0]  n_icode;
    logic [3:0]  n_ifun;
    logic [3:0]  n_ra;
    logic [3:0]  n_rb;
    logic [63:0] n_valc;
    logic [63:0] n_valp;
    logic        n_valid;
    logic        n_err;

    imem #(.MEM_BYTES(MEM_BYTES)) u_imem (
        .clk     (clk),
        .we      (imem_we),
        .waddr   (imem_waddr),
        .wdata   (imem_wdata),
        .pc      (PC),
        .rdata_c (rd_c),
        .oor_c   (oor_c)
    );

    // Decode the fetched bytes; a memory error overrides the validity check.
    always_comb begin
        ic_c    = rd_c[0][7:4];
        fn_c    = rd_c[0][3:0];
        len_c   = instr_len(ic_c);
        err_c   = 1'b0;
        n_icode = ic_c;
        n_ifun  = fn_c;
        n_ra    = RNONE;
        n_rb    = RNONE;
        n_valc  = 64'd0;
        n_valp  = PC + 64'(len_c);
        n_valid = 1'b1;
        n_err   = 1'b0;

        for (int unsigned i = 0; i < INSTR_MAX_BYTES; i++) begin
            if ((4'(i) < len_c) && oor_c[i]) begin
                err_c = 1'b1;
            end
        end

        if (err_c) begin
            n_icode = I_NOP;
            n_ifun  = 4'd0;
            n_valp  = PC;
            n_err   = 1'b1;
        end else if (!ifun_legal(ic_c, fn_c)) begin
            n_valid = 1'b0;
            n_valp  = PC + 64'd1;
        end else begin
            if (need_regids(ic_c)) begin
                n_ra = rd_c[1][7:4];
                n_rb = rd_c[1][3:0];
            end
            if (need_valC(ic_c)) begin
                n_valc = need_regids(ic_c) ? rd_c[9:2] : rd_c[8:1];
            end
        end
    end

    // Output register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icode       <= 4'd0;
            ifun        <= 4'd0;
            rA          <= RNONE;
            rB          <= RNONE;
            valC        <= 64'd0;
            valP        <= 64'd0;
            instr_valid <= 1'b1;
            imem_error  <= 1'b0;
        end else begin
            icode       <= n_icode;
            ifun        <= n_ifun;
            rA          <= n_ra;
            rB          <= n_rb;
            valC        <= n_valc;
            valP        <= n_valp;
            instr_valid <= n_valid;
            imem_error  <= n_err;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: directed program fragments plus
// randomized fetches and writes against a byte-array reference model.
module tb_fetch;

    localparam int MEM = 1024;

    logic        clk;
    logic        rst_n;
    logic [63:0] PC;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] ref_mem [MEM];

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        valid;
        logic        err;
    } exp_t;

    fetch #(.MEM_BYTES(MEM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC          (PC),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .instr_valid (instr_valid),
        .imem_error  (imem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: what the fetch stage should report for this PC and memory image.
    function automatic exp_t model(input logic rst, input logic [63:0] pc);
        exp_t e;
        int   len;
        int   off;
        int   base;
        logic [3:0] ic;
        logic [3:0] fn;
        logic legal;
        e = '{icode:4'h0, ifun:4'h0, ra:4'hF, rb:4'hF, valc:64'd0, valp:64'd0, valid:1'b1, err:1'b0};
        if (!rst) return e;
        if (pc >= 64'(MEM)) begin
            e.icode = 4'h1; e.valp = pc; e.err = 1'b1;
            return e;
        end
        base = int'(pc);
        ic = ref_mem[base][7:4];
        fn = ref_mem[base][3:0];
        if (ic inside {4'h2, 4'h6, 4'hA, 4'hB})      len = 2;
        else if (ic inside {4'h3, 4'h4, 4'h5})       len = 10;
        else if (ic inside {4'h7, 4'h8})             len = 9;
        else                                         len = 1;
        if (base + len - 1 >= MEM) begin
            e.icode = 4'h1; e.valp = pc; e.err = 1'b1;
            return e;
        end
        if (ic > 4'hB)                    legal = 1'b0;
        else if (ic == 4'h2 || ic == 4'h7) legal = (fn <= 4'd6);
        else if (ic == 4'h6)              legal = (fn <= 4'd3);
        else                              legal = (fn == 4'd0);
        e.icode = ic;
        e.ifun  = fn;
        if (!legal) begin
            e.valid = 1'b0;
            e.valp  = pc + 64'd1;
            return e;
        end
        e.valp = pc + 64'(len);
        if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
            e.ra = ref_mem[base+1][7:4];
            e.rb = ref_mem[base+1][3:0];
        end
        if (ic inside {4'h3, 4'h4, 4'h5}) off = 2;
        else if (ic inside {4'h7, 4'h8})  off = 1;
        else                              off = 0;
        if (off != 0) begin
            for (int k = 0; k < 8; k++) begin
                e.valc = e.valc | (64'(ref_mem[base+off+k]) << (8*k));
            end
        end
        return e;
    endfunction

    // One clock: drive inputs, predict, advance, compare all outputs.
    task automatic step(input logic rst, input logic [63:0] pc, input logic we,
                        input logic [63:0] wa, input logic [7:0] wd);
        exp_t e;
        rst_n      = rst;
        PC         = pc;
        imem_we    = we;
        imem_waddr = wa;
        imem_wdata = wd;
        e = model(rst, pc);
        @(posedge clk);
        if (we && (wa < 64'(MEM))) ref_mem[int'(wa)] = wd;
        @(negedge clk);
        check($sformatf("icode@%0h", pc), 64'(icode), 64'(e.icode));
        check($sformatf("ifun@%0h", pc),  64'(ifun),  64'(e.ifun));
        check($sformatf("rA@%0h", pc),    64'(rA),    64'(e.ra));
        check($sformatf("rB@%0h", pc),    64'(rB),    64'(e.rb));
        check($sformatf("valC@%0h", pc),  valC,       e.valc);
        check($sformatf("valP@%0h", pc),  valP,       e.valp);
        check($sformatf("valid@%0h", pc), 64'(instr_valid), 64'(e.valid));
        check($sformatf("err@%0h", pc),   64'(imem_error),  64'(e.err));
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        step(1'b1, 64'd0, 1'b1, 64'(addr), data);
    endtask

    initial begin
        logic [7:0]  prog [];
        logic [63:0] pc;
        logic [63:0] wa;
        logic        we;
        logic        rst;
        int          sel;

        rst_n = 1'b0; PC = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        @(negedge clk);

        // Fill memory while held in reset: checks reset values and write-in-reset.
        for (int a = 0; a < MEM; a++) step(1'b0, 64'(a), 1'b1, 64'(a), 8'($urandom));

        // Directed program fragments.
        prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        foreach (prog[i]) wr(50 + i, prog[i]);
        prog = '{8'h60, 8'h20, 8'h70, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        foreach (prog[i]) wr(60 + i, prog[i]);
        prog = '{8'h90, 8'hC0, 8'h27, 8'h63, 8'h12};
        foreach (prog[i]) wr(80 + i, prog[i]);
        wr(1014, 8'h30);
        wr(1022, 8'h30);

        step(1'b1, 64'd50, 1'b0, 64'd0, 8'd0);
        check("tp_irmovq_icode", 64'(icode), 64'd3);
        check("tp_irmovq_rA", 64'(rA), 64'hF);
        check("tp_irmovq_rB", 64'(rB), 64'd2);
        check("tp_irmovq_valC", valC, 64'd10);
        check("tp_irmovq_valP", valP, 64'd60);
        step(1'b1, valP, 1'b0, 64'd0, 8'd0);
        check("tp_opq_rA", 64'(rA), 64'd2);
        check("tp_opq_valP", valP, 64'd62);
        step(1'b1, valP, 1'b0, 64'd0, 8'd0);
        check("tp_jxx_valC", valC, 64'd256);
        check("tp_jxx_valP", valP, 64'd71);
        step(1'b1, valP, 1'b0, 64'd0, 8'd0);
        check("tp_halt_icode", 64'(icode), 64'd0);
        check("tp_halt_valP", valP, 64'd72);
        step(1'b1, 64'd80, 1'b0, 64'd0, 8'd0);
        check("tp_ret_valP", valP, 64'd81);
        step(1'b1, 64'd81, 1'b0, 64'd0, 8'd0);
        check("tp_c0_valid", 64'(instr_valid), 64'd0);
        step(1'b1, 64'd82, 1'b0, 64'd0, 8'd0);
        check("tp_27_valid", 64'(instr_valid), 64'd0);
        step(1'b1, 64'd83, 1'b0, 64'd0, 8'd0);
        check("tp_63_valid", 64'(instr_valid), 64'd1);
        step(1'b1, 64'd1014, 1'b0, 64'd0, 8'd0);
        check("tp_lastfit_err", 64'(imem_error), 64'd0);
        step(1'b1, 64'(MEM - 2), 1'b0, 64'd0, 8'd0);
        check("tp_oor_err", 64'(imem_error), 64'd1);
        check("tp_oor_valP", valP, 64'(MEM - 2));
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 8'd0);
        check("tp_maxpc_err", 64'(imem_error), 64'd1);

        // Reset mid-run, then memory must still hold the program.
        step(1'b0, 64'd50, 1'b0, 64'd0, 8'd0);
        step(1'b1, 64'd50, 1'b0, 64'd0, 8'd0);
        check("tp_post_reset_valC", valC, 64'd10);

        // Same-cycle write and fetch of one byte returns the old byte.
        step(1'b1, 64'd71, 1'b1, 64'd71, 8'h10);
        check("tp_rbw_old", 64'(icode), 64'd0);
        step(1'b1, 64'd71, 1'b0, 64'd0, 8'd0);
        check("tp_rbw_new", 64'(icode), 64'd1);

        // Randomized fetches with concurrent writes.
        for (int n = 0; n < 2000; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       pc = 64'($urandom_range(0, MEM - 1));
            else if (sel == 7) pc = 64'($urandom_range(MEM - 10, MEM - 1));
            else if (sel == 8) pc = {$urandom, $urandom};
            else               pc = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 12));
            we  = ($urandom_range(0, 1) == 1);
            sel = int'($urandom_range(0, 9));
            if (sel < 2)       wa = pc;
            else if (sel < 4)  wa = {$urandom, $urandom};
            else               wa = 64'($urandom_range(0, MEM - 1));
            rst = ($urandom_range(0, 31) != 0);
            step(rst, pc, we, wa, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
